// File: rtl/riscv_store_buffer.sv
// Posted-write store buffer: DEPTH-entry FIFO between the core store path and data memory.
// Optional STORE_FWD_EN: per-entry word-address compare for precise load hazards.
module riscv_store_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              st_valid,
  output logic              st_ready,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [31:0]       st_data,
  input  logic [1:0]        st_size,
  output logic              misalign,
  input  logic [ADDR_W-1:0] ld_addr,
  output logic              ld_hazard,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  output logic              MemWrite,
  output logic              empty
);
  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0]     r_wr_ptr, r_rd_ptr;
  logic [PW:0]       r_count;
  logic [ADDR_W-3:0] r_waddr [DEPTH];
  logic [31:0]       r_data  [DEPTH];
  logic [3:0]        r_be    [DEPTH];

  logic [1:0]  w_a;
  logic [3:0]  w_be;
  logic [31:0] w_data;
  logic        w_bad, w_full, w_push, w_pop;

  assign w_a = st_addr[1:0];

  always_comb begin
    w_be   = 4'b0000;
    w_data = st_data;
    w_bad  = 1'b1;
    case (st_size)
      2'd0: begin w_be = 4'b0001 << w_a; w_data = {4{st_data[7:0]}};  w_bad = 1'b0;        end
      2'd1: begin w_be = 4'b0011 << w_a; w_data = {2{st_data[15:0]}}; w_bad = w_a[0];      end
      2'd2: begin w_be = 4'b1111;        w_data = st_data;            w_bad = (w_a != 2'd0); end
      default: ;
    endcase
  end

  assign misalign  = st_valid & w_bad;
  assign w_full    = (r_count == (PW+1)'(DEPTH));
  assign empty     = (r_count == '0);
  assign st_ready  = !w_full;
  // Gated by reset so no write can retire in a reset cycle.
  assign mem_valid = !empty & reset;
  assign MemWrite  = mem_valid & mem_ready;
  assign w_push    = st_valid & st_ready & !w_bad;
  assign w_pop     = MemWrite;

  assign mem_addr  = {r_waddr[r_rd_ptr], 2'b00};
  assign mem_wdata = r_data[r_rd_ptr];
  assign mem_be    = r_be[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_waddr[r_wr_ptr] <= st_addr[ADDR_W-1:2];
        r_data[r_wr_ptr]  <= w_data;
        r_be[r_wr_ptr]    <= w_be;
        r_wr_ptr          <= r_wr_ptr + PW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PW+1)'(1);
        2'b01:   r_count <= r_count - (PW+1)'(1);
        default: ;
      endcase
    end
  end

`ifdef STORE_FWD_EN
  logic          w_hazard;
  logic [PW-1:0] w_off;
  logic          w_unused_ld;

  // Entry i is live when its distance from the head is below the occupancy.
  always_comb begin
    w_hazard = 1'b0;
    w_off    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_off = PW'(i) - r_rd_ptr;
      if (({1'b0, w_off} < r_count) && (r_waddr[i] == ld_addr[ADDR_W-1:2]))
        w_hazard = 1'b1;
    end
  end

  assign ld_hazard   = w_hazard;
  assign w_unused_ld = ^ld_addr[1:0];
`else
  logic w_unused_ld;

  assign ld_hazard   = !empty;
  assign w_unused_ld = ^ld_addr;
`endif

endmodule
